// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between the hazard/control units and the pipeline
// sequencer. The master side raises requests and observes the pipeline
// controls; the slave side is the sequencer itself.
interface pipe_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             ld_use_req;
   logic             br_taken;
   logic             halt_req;
   logic             imem_stall;
   logic             dmem_stall;
   logic             pc_we;
   logic             fd_we;
   logic             fd_flush;
   logic             de_we;
   logic             de_bubble;
   logic             em_we;
   logic             mw_we;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output ld_use_req, br_taken, halt_req, imem_stall, dmem_stall,
      input  pc_we, fd_we, fd_flush, de_we, de_bubble, em_we, mw_we,
             halted, stall_cnt
   );

   modport slave (
      input  ld_use_req, br_taken, halt_req, imem_stall, dmem_stall,
      output pc_we, fd_we, fd_flush, de_we, de_bubble, em_we, mw_we,
             halted, stall_cnt
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer. Arbitrates memory stalls, taken branches, load-use
// hazards and halt requests into write-enable / flush / bubble controls for
// the PC and the FD/DE/EM/MW registers, drains the pipe on halt and keeps a
// saturating count of cycles in which the PC did not advance.
// Arbitration order: dmem_stall > imem_stall > br_taken > ld_use_req > halt_req.
module pipe_ctrl #(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic        clk,
   input  logic        rst,
   pipe_ctrl_if.slave  bus
);

   localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_LU_BUB = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [DRN_W-1:0]   drn_r;
   logic [DRN_W-1:0]   drn_nxt_s;
   logic [CNT_W-1:0]   stall_cnt_r;
   // Set once a held load-use request has been served, so that a request
   // still asserted after the bubble does not insert a second one.
   logic               lu_hold_r;
   logic               lu_hold_nxt_s;
   logic               lu_eff_s;

   logic pc_we_s, fd_we_s, fd_flush_s, de_we_s, de_bubble_s;
   logic em_we_s, mw_we_s, halted_s;

   assign lu_eff_s = bus.ld_use_req & ~lu_hold_r;

   // State, drain counter and load-use bookkeeping registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= ST_RUN;
         drn_r     <= {DRN_W{1'b0}};
         lu_hold_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         drn_r     <= drn_nxt_s;
         lu_hold_r <= lu_hold_nxt_s;
      end
   end

   // Saturating count of non-halted cycles in which the PC is held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (!pc_we_s && (state_r != ST_HALTED) && (stall_cnt_r != CNT_MAX)) begin
         stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   // Next-state and pipeline control decode.
   always_comb begin
      pc_we_s       = 1'b0;
      fd_we_s       = 1'b0;
      fd_flush_s    = 1'b0;
      de_we_s       = 1'b0;
      de_bubble_s   = 1'b0;
      em_we_s       = 1'b0;
      mw_we_s       = 1'b0;
      halted_s      = 1'b0;
      state_nxt_s   = state_r;
      drn_nxt_s     = drn_r;
      lu_hold_nxt_s = lu_hold_r;

      if (!rst) begin
         // Everything stays deasserted while reset is held.
         state_nxt_s = ST_RUN;
      end else begin
         case (state_r)
            ST_RUN, ST_LU_BUB: begin
               if (bus.dmem_stall) begin
                  // Whole pipe frozen; state and bookkeeping held.
                  state_nxt_s = state_r;
               end else begin
                  pc_we_s     = 1'b1;
                  fd_we_s     = 1'b1;
                  de_we_s     = 1'b1;
                  em_we_s     = 1'b1;
                  mw_we_s     = 1'b1;
                  state_nxt_s = ST_RUN;
                  if (!bus.ld_use_req) begin
                     lu_hold_nxt_s = 1'b0;
                  end else begin
                     lu_hold_nxt_s = lu_hold_r;
                  end

                  if (bus.imem_stall) begin
                     pc_we_s    = 1'b0;
                     fd_flush_s = 1'b1;
                     if (bus.br_taken) begin
                        de_bubble_s = 1'b1;
                     end else begin
                        de_bubble_s = 1'b0;
                     end
                  end else if (bus.br_taken) begin
                     fd_flush_s  = 1'b1;
                     de_bubble_s = 1'b1;
                  end else if ((state_r == ST_RUN) && lu_eff_s) begin
                     pc_we_s       = 1'b0;
                     fd_we_s       = 1'b0;
                     de_bubble_s   = 1'b1;
                     lu_hold_nxt_s = 1'b1;
                     state_nxt_s   = ST_LU_BUB;
                  end else if ((state_r == ST_RUN) && bus.halt_req) begin
                     pc_we_s     = 1'b0;
                     fd_flush_s  = 1'b1;
                     drn_nxt_s   = DRN_LOAD;
                     state_nxt_s = ST_DRAIN;
                  end else begin
                     state_nxt_s = ST_RUN;
                  end
               end
            end

            ST_DRAIN: begin
               if (bus.dmem_stall) begin
                  state_nxt_s = ST_DRAIN;
               end else begin
                  // Fetch side fills with NOPs while the back end empties.
                  fd_we_s     = 1'b1;
                  fd_flush_s  = 1'b1;
                  de_we_s     = 1'b1;
                  de_bubble_s = 1'b1;
                  em_we_s     = 1'b1;
                  mw_we_s     = 1'b1;
                  if (!bus.ld_use_req) begin
                     lu_hold_nxt_s = 1'b0;
                  end else begin
                     lu_hold_nxt_s = lu_hold_r;
                  end
                  if (drn_r == {DRN_W{1'b0}}) begin
                     state_nxt_s = ST_HALTED;
                  end else begin
                     drn_nxt_s = drn_r - DRN_W'(1);
                  end
               end
            end

            ST_HALTED: begin
               halted_s    = 1'b1;
               state_nxt_s = ST_HALTED;
            end

            default: begin
               state_nxt_s = ST_RUN;
            end
         endcase
      end
   end

   assign bus.pc_we     = pc_we_s;
   assign bus.fd_we     = fd_we_s;
   assign bus.fd_flush  = fd_flush_s;
   assign bus.de_we     = de_we_s;
   assign bus.de_bubble = de_bubble_s;
   assign bus.em_we     = em_we_s;
   assign bus.mw_we     = mw_we_s;
   assign bus.halted    = halted_s;
   assign bus.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. Each driven cycle pushes its expected
// controls and counter value into a queue; a monitor on the falling edge
// pops and compares against the DUT.
module tb_pipe_ctrl;

   localparam int CW = 4;

   // Request bits: {ld_use_req, br_taken, halt_req, imem_stall, dmem_stall}
   localparam logic [4:0] R0 = 5'b00000;
   localparam logic [4:0] LU = 5'b10000;
   localparam logic [4:0] BR = 5'b01000;
   localparam logic [4:0] HT = 5'b00100;
   localparam logic [4:0] IM = 5'b00010;
   localparam logic [4:0] DM = 5'b00001;

   // Control bits: {pc_we, fd_we, fd_flush, de_we, de_bubble, em_we, mw_we, halted}
   localparam logic [7:0] ALL0 = 8'b0000_0000;
   localparam logic [7:0] RUNV = 8'b1101_0110;
   localparam logic [7:0] LUV  = 8'b0001_1110;
   localparam logic [7:0] BRV  = 8'b1111_1110;
   localparam logic [7:0] IMV  = 8'b0111_0110;
   localparam logic [7:0] IMBR = 8'b0111_1110;
   localparam logic [7:0] HRUN = 8'b0111_0110;
   localparam logic [7:0] DRV  = 8'b0111_1110;
   localparam logic [7:0] HLT  = 8'b0000_0001;

   typedef struct {
      logic [7:0]    ctl;
      logic [CW-1:0] cnt;
      string         nm;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   pipe_ctrl_if #(.CNT_W(CW)) bus ();

   pipe_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step(input logic [4:0] rq, input logic rv,
                       input logic [7:0] ec, input logic [CW-1:0] en,
                       input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst = rv;
      {bus.ld_use_req, bus.br_taken, bus.halt_req, bus.imem_stall, bus.dmem_stall} = rq;
      e.ctl = ec;
      e.cnt = en;
      e.nm  = nm;
      exp_q.push_back(e);
   endtask

   // Monitor: compare every cycle that has a pending expectation.
   always @(negedge clk) begin
      logic [7:0] got;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         got = {bus.pc_we, bus.fd_we, bus.fd_flush, bus.de_we, bus.de_bubble,
                bus.em_we, bus.mw_we, bus.halted};
         n_cmp = n_cmp + 1;
         if ((got !== mon_e.ctl) || (bus.stall_cnt !== mon_e.cnt)) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                     mon_e.nm, got, bus.stall_cnt, mon_e.ctl, mon_e.cnt);
         end
      end
   end

   initial begin
      {bus.ld_use_req, bus.br_taken, bus.halt_req, bus.imem_stall, bus.dmem_stall} = R0;

      step(R0, 1'b0, ALL0, 4'd0, "reset");
      step(R0, 1'b1, RUNV, 4'd0, "run_idle");

      // load-use held for three cycles: exactly one bubble
      step(LU, 1'b1, LUV,  4'd0, "lu_c1");
      step(LU, 1'b1, RUNV, 4'd1, "lu_c2");
      step(LU, 1'b1, RUNV, 4'd1, "lu_c3");
      step(R0, 1'b1, RUNV, 4'd1, "lu_release");

      // branch wins over load-use, state stays RUN
      step(LU | BR, 1'b1, BRV,  4'd1, "br_lu");
      step(R0,      1'b1, RUNV, 4'd1, "after_br");

      // dmem stall while in LU_BUB
      step(LU, 1'b1, LUV,  4'd1, "lu_then_dm");
      step(DM, 1'b1, ALL0, 4'd2, "dm_1");
      step(DM, 1'b1, ALL0, 4'd3, "dm_2");
      step(DM, 1'b1, ALL0, 4'd4, "dm_3");
      step(DM, 1'b1, ALL0, 4'd5, "dm_4");
      step(R0, 1'b1, RUNV, 4'd6, "lubub_after_dm");
      step(LU, 1'b1, LUV,  4'd6, "back_in_run");
      step(R0, 1'b1, RUNV, 4'd7, "lubub_2");

      // imem stall, with and without a branch
      step(IM | BR, 1'b1, IMBR, 4'd7, "im_br");
      step(IM,      1'b1, IMV,  4'd8, "im_only");
      step(R0,      1'b1, RUNV, 4'd9, "im_done");

      // halt: one RUN cycle, three DRAIN cycles, then HALTED
      step(HT,           1'b1, HRUN, 4'd9,  "halt_run");
      step(R0,           1'b1, DRV,  4'd10, "drain_1");
      step(LU | BR | IM, 1'b1, DRV,  4'd11, "drain_2");
      step(HT,           1'b1, DRV,  4'd12, "drain_3");
      step(LU|BR|HT|IM|DM, 1'b1, HLT, 4'd13, "halted_a");
      step(LU | BR,      1'b1, HLT,  4'd13, "halted_b");
      step(R0,           1'b1, HLT,  4'd13, "halted_c");

      // reset out of HALTED, then reset in the middle of DRAIN
      step(R0, 1'b0, ALL0, 4'd0, "rst_halted");
      step(R0, 1'b1, RUNV, 4'd0, "rst_rel_1");
      step(HT, 1'b1, HRUN, 4'd0, "halt_run_2");
      step(R0, 1'b1, DRV,  4'd1, "drain_b1");
      step(R0, 1'b0, ALL0, 4'd0, "rst_mid_drain");
      step(R0, 1'b1, RUNV, 4'd0, "rst_rel_2");

      // dmem stall freezes the drain counter
      step(HT, 1'b1, HRUN, 4'd0, "halt_run_3");
      step(DM, 1'b1, ALL0, 4'd1, "drain_dm");
      step(R0, 1'b1, DRV,  4'd2, "drain_c1");
      step(R0, 1'b1, DRV,  4'd3, "drain_c2");
      step(R0, 1'b1, DRV,  4'd4, "drain_c3");
      step(R0, 1'b1, HLT,  4'd5, "halted_d");
      step(R0, 1'b0, ALL0, 4'd0, "rst_3");
      step(R0, 1'b1, RUNV, 4'd0, "rst_rel_3");

      // saturation: 20 imem stall cycles with a 4-bit counter
      for (int i = 0; i < 20; i++) begin
         step(IM, 1'b1, IMV, CW'((i < 15) ? i : 15), "sat_im");
      end
      step(DM, 1'b1, ALL0, 4'd15, "sat_dm");
      step(R0, 1'b1, RUNV, 4'd15, "sat_hold");
      step(R0, 1'b1, RUNV, 4'd15, "sat_final");

      // let the monitor drain the queue, bounded
      for (int k = 0; k < 10; k++) begin
         if (exp_q.size() > 0) begin
            @(negedge clk);
            #1;
         end
      end
      if (exp_q.size() > 0) begin
         n_bad = n_bad + exp_q.size();
         $display("FAIL queue_drain: pending=%0d, expected pending=0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
